// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums a programmed number of 2*WIDTH-bit products.
// Build option: define MAC_SATURATE_EN to clamp the accumulator at all-ones on overflow.
module mac_accumulator #(
  parameter int WIDTH       = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] term_count,
  input  logic                   clear,
  input  logic [2*WIDTH-1:0]     product,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_WIDTH-1:0]   out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow
);

  if (ACC_WIDTH < 2*WIDTH) begin : g_width_check
    $error("mac_accumulator: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH:0]     sum;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   accept;

  assign sum    = {1'b0, acc} + (ACC_WIDTH+1)'(product);
  assign accept = in_valid & in_ready;
  assign out    = acc;

  // Products are unsigned, so a clamped accumulator stays at all-ones for the rest of the run.
  always_comb begin
    acc_next = sum[ACC_WIDTH-1:0];
`ifdef MAC_SATURATE_EN
    if (sum[ACC_WIDTH]) acc_next = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            overflow <= 1'b0;
            if (term_count != '0) begin
              remaining <= term_count;
              state     <= ACCUM;
              in_ready  <= 1'b1;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc       <= acc_next;
            remaining <= remaining - COUNT_WIDTH'(1);
            if (sum[ACC_WIDTH]) overflow <= 1'b1;
            if (remaining == COUNT_WIDTH'(1)) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
